bp_resolve_queue: RTL and testbench

- Downstream companion of the gshare predictor top.
- Captures every completed prediction (PC, predicted direction, predicted target) in an in-order FIFO of in-flight branches.
- When the execute stage reports the real outcome, compares it against the oldest entry and drives the predictor's resolve handshake (start_resolve, PC, actual_target, pr_hit).
- On a mispredict, issues a one-cycle fetch redirect and flushes all younger wrong-path entries.

---
 rtl/bp_resolve_queue.sv | 150 +++++++++++++++
 tb/tb_bp_resolve_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve_queue.sv
// In-order queue of in-flight branch predictions. Compares the oldest entry
// against the execute-stage outcome, drives the predictor's resolve handshake,
// and on a mispredict flushes wrong-path entries and pulses a fetch redirect.
module bp_resolve_queue #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [W-1:0]     pred_pc,
    input  logic             pred_taken,
    input  logic [W-1:0]     pred_target,
    output logic             q_full,
    output logic [PTR_W:0]   q_count,
    input  logic             ex_valid,
    input  logic             ex_taken,
    input  logic [W-1:0]     ex_target,
    output logic             ex_ready,
    output logic             start_resolve,
    output logic [W-1:0]     res_pc,
    output logic [W-1:0]     actual_target,
    output logic             pr_hit,
    input  logic             resolve_done,
    output logic             redirect_valid,
    output logic [W-1:0]     redirect_pc
);

    localparam logic [PTR_W:0]   DepthCnt = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CntOne   = 1;
    localparam logic [PTR_W-1:0] PtrOne   = 1;
    localparam logic [W-1:0]     InstrLen = 4;

    typedef enum logic {StIdle, StResolve} state_t;

    state_t            state;
    logic [W-1:0]      pc_mem     [DEPTH];
    logic [W-1:0]      target_mem [DEPTH];
    logic [DEPTH-1:0]  taken_mem;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_d;

    logic              hs;
    logic              hit;
    logic              mispredict;
    logic              enq;
    logic [W-1:0]      head_pc;
    logic [W-1:0]      head_target;
    logic              head_taken;
    logic [W-1:0]      correct_pc;

    assign q_full   = (count == DepthCnt);
    assign q_count  = count;
    assign ex_ready = (state == StIdle) && (count != '0);

    assign head_pc     = pc_mem[rd_ptr];
    assign head_target = target_mem[rd_ptr];
    assign head_taken  = taken_mem[rd_ptr];

    assign hs         = ex_valid && ex_ready;
    assign hit        = (head_taken == ex_taken) && (!ex_taken || (head_target == ex_target));
    assign mispredict = hs && !hit;
    // Predictions arriving in the mispredict cycle are wrong-path and dropped.
    assign enq        = pred_valid && !q_full && !mispredict;
    assign correct_pc = ex_taken ? ex_target : head_pc + InstrLen;

    // Next occupancy: flush wins, otherwise net of enqueue and pop.
    always_comb begin
        count_d = count;
        if (mispredict) begin
            count_d = '0;
        end else begin
            unique case ({enq, hs})
                2'b10:   count_d = count + CntOne;
                2'b01:   count_d = count - CntOne;
                default: count_d = count;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates all reads.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]     <= pred_pc;
            target_mem[wr_ptr] <= pred_target;
            taken_mem[wr_ptr]  <= pred_taken;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PtrOne;
            end
            // Flush empties the queue by catching the read pointer up.
            if (mispredict) begin
                rd_ptr <= wr_ptr;
            end else if (hs) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
            count <= count_d;
        end
    end

    // Resolve FSM with registered handshake and redirect outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            start_resolve  <= 1'b0;
            res_pc         <= '0;
            actual_target  <= '0;
            pr_hit         <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (hs) begin
                        state         <= StResolve;
                        start_resolve <= 1'b1;
                        res_pc        <= head_pc;
                        actual_target <= correct_pc;
                        pr_hit        <= hit;
                        if (!hit) begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= correct_pc;
                        end
                    end
                end
                StResolve: begin
                    if (resolve_done) begin
                        state         <= StIdle;
                        start_resolve <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Self-checking bench for bp_resolve_queue: directed scenarios then random
// traffic, compared against a queue-based behavioural model.
module tb_bp_resolve_queue;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             pred_valid;
    logic [W-1:0]     pred_pc;
    logic             pred_taken;
    logic [W-1:0]     pred_target;
    logic             q_full;
    logic [PTR_W:0]   q_count;
    logic             ex_valid;
    logic             ex_taken;
    logic [W-1:0]     ex_target;
    logic             ex_ready;
    logic             start_resolve;
    logic [W-1:0]     res_pc;
    logic [W-1:0]     actual_target;
    logic             pr_hit;
    logic             resolve_done;
    logic             redirect_valid;
    logic [W-1:0]     redirect_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bp_resolve_queue #(.W(W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .q_full         (q_full),
        .q_count        (q_count),
        .ex_valid       (ex_valid),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_ready       (ex_ready),
        .start_resolve  (start_resolve),
        .res_pc         (res_pc),
        .actual_target  (actual_target),
        .pr_hit         (pr_hit),
        .resolve_done   (resolve_done),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Behavioural model: in-flight predictions as a plain queue.
    typedef struct {
        logic [W-1:0] pc;
        logic         tk;
        logic [W-1:0] tg;
    } ent_t;

    ent_t         mq[$];
    bit           busy;
    bit           e_start;
    logic [W-1:0] e_res_pc;
    logic [W-1:0] e_at;
    bit           e_hit;
    bit           e_rv;
    logic [W-1:0] e_rpc;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        busy    = 0;
        e_start = 0;
        e_rv    = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".count"}, W'(q_count), W'(mq.size()));
        chk({tag, ".full"}, W'(q_full), W'(mq.size() == DEPTH));
        chk({tag, ".ex_ready"}, W'(ex_ready), W'(!busy && mq.size() != 0));
        chk({tag, ".start"}, W'(start_resolve), W'(e_start));
        chk({tag, ".redir"}, W'(redirect_valid), W'(e_rv));
        if (e_start) begin
            chk({tag, ".res_pc"}, res_pc, e_res_pc);
            chk({tag, ".act_tgt"}, actual_target, e_at);
            chk({tag, ".hit"}, W'(pr_hit), W'(e_hit));
        end
        if (e_rv) chk({tag, ".redir_pc"}, redirect_pc, e_rpc);
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input string tag, input bit pv, input logic [W-1:0] ppc, input bit pt,
                        input logic [W-1:0] ptg, input bit exv, input bit ext,
                        input logic [W-1:0] extg, input bit rd);
        ent_t h;
        bit   hs, hit, was_full, flush;
        pred_valid   = pv;
        pred_pc      = ppc;
        pred_taken   = pt;
        pred_target  = ptg;
        ex_valid     = exv;
        ex_taken     = ext;
        ex_target    = extg;
        resolve_done = rd;
        was_full = (mq.size() == DEPTH);
        hs       = exv && !busy && (mq.size() != 0);
        flush    = 0;
        e_rv     = 0;
        if (busy && rd) begin
            busy    = 0;
            e_start = 0;
        end
        if (hs) begin
            h        = mq.pop_front();
            hit      = (h.tk == ext) && (!ext || h.tg == extg);
            e_start  = 1;
            e_res_pc = h.pc;
            e_at     = ext ? extg : h.pc + 4;
            e_hit    = hit;
            busy     = 1;
            if (!hit) begin
                mq.delete();
                flush = 1;
                e_rv  = 1;
                e_rpc = e_at;
            end
        end
        if (pv && !was_full && !flush) mq.push_back('{ppc, pt, ptg});
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic enq(input string tag, input logic [W-1:0] pc, input bit tk, input logic [W-1:0] tg);
        step(tag, 1, pc, tk, tg, 0, 0, 0, 0);
    endtask

    task automatic idle(input string tag, input bit rd);
        step(tag, 0, 0, 0, 0, 0, 0, 0, rd);
    endtask

    // Resolve the head with a correct outcome, then complete the handshake.
    task automatic pop_hit(input string tag);
        ent_t h;
        h = mq[0];
        step(tag, 0, 0, 0, 0, 1, h.tk, h.tg, 0);
        idle(tag, 1);
    endtask

    initial begin
        logic [W-1:0] rpc, rtg, xtg;
        bit           rtk, xtk, xv;
        ent_t         h;

        // Reset with ex_valid asserted: nothing should start.
        rst = 1; pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
        ex_valid = 1; ex_taken = 1; ex_target = 32'h1234; resolve_done = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ex_ready", W'(ex_ready), 0);
        chk("rst.start", W'(start_resolve), 0);
        chk("rst.count", W'(q_count), 0);
        chk("rst.redir", W'(redirect_valid), 0);
        chk("rst.res_pc", res_pc, 0);
        chk("rst.full", W'(q_full), 0);
        rst = 0;
        idle("post_rst", 0);
        step("ex_on_empty", 0, 0, 0, 0, 1, 1, 32'h99, 0);

        // Correct taken prediction.
        enq("tk_enq", 32'h1000, 1, 32'h1000_0000);
        step("tk_hs", 0, 0, 0, 0, 1, 1, 32'h1000_0000, 0);
        chk("tk.res_pc", res_pc, 32'h1000);
        chk("tk.hit", W'(pr_hit), 1);
        idle("tk_hold", 0);
        chk("tk.held", W'(start_resolve), 1);
        step("tk_ex_busy", 0, 0, 0, 0, 1, 0, 0, 0);
        idle("tk_done", 1);
        chk("tk.dropped", W'(start_resolve), 0);
        idle("done_idle", 1);

        // Direction mispredict, flush, and dropped same-cycle enqueue.
        enq("dm_e0", 32'h2000, 0, 32'h2222);
        enq("dm_e1", 32'h3000, 1, 32'h3333);
        enq("dm_e2", 32'h4000, 1, 32'h4444);
        step("dm_hs", 1, 32'h5000, 0, 0, 1, 1, 32'h2000_0000, 0);
        chk("dm.count", W'(q_count), 0);
        chk("dm.redir_pc", redirect_pc, 32'h2000_0000);
        chk("dm.hit", W'(pr_hit), 0);
        enq("dm_after", 32'h6000, 0, 0);
        chk("dm.redir_pulse", W'(redirect_valid), 0);
        idle("dm_done", 1);
        pop_hit("dm_clear");

        // Target mispredict.
        enq("tm_enq", 32'h4000, 1, 32'h4000_0000);
        step("tm_hs", 0, 0, 0, 0, 1, 1, 32'h4400_0000, 0);
        chk("tm.act_tgt", actual_target, 32'h4400_0000);
        chk("tm.redir_pc", redirect_pc, 32'h4400_0000);
        idle("tm_done", 1);

        // Not-taken correct.
        enq("nt_enq", 32'h5000, 0, 32'hdead_beef);
        step("nt_hs", 0, 0, 0, 0, 1, 0, 32'h1357_9bdf, 0);
        chk("nt.act_tgt", actual_target, 32'h5004);
        chk("nt.hit", W'(pr_hit), 1);
        idle("nt_done", 1);

        // Fill, overflow, wrap.
        for (int i = 0; i < DEPTH; i++) enq("fill", 32'h8000 + 32'(i * 16), 1, 32'h9000 + 32'(i));
        chk("full.flag", W'(q_full), 1);
        enq("overflow", 32'hbad0, 1, 32'hbad0);
        chk("full.count", W'(q_count), DEPTH);
        pop_hit("wrap_pop0");
        pop_hit("wrap_pop1");
        enq("wrap_e0", 32'ha000, 0, 0);
        enq("wrap_e1", 32'ha010, 1, 32'ha0a0);
        chk("wrap.count", W'(q_count), DEPTH);
        while (mq.size() > 1) pop_hit("wrap_drain");
        h = mq[0];
        step("rst_mid", 0, 0, 0, 0, 1, h.tk, h.tg, 0);
        chk("wrap.last_pc", res_pc, 32'ha010);
        // Asynchronous reset in the middle of RESOLVE.
        #2 rst = 1;
        #1;
        model_reset();
        chk("amid.start", W'(start_resolve), 0);
        chk("amid.count", W'(q_count), 0);
        chk("amid.redir", W'(redirect_valid), 0);
        @(posedge clk);
        #1 rst = 0;
        idle("amid_after", 0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rpc = $urandom & 32'hffff_fffc;
            rtg = $urandom & 32'hffff_fffc;
            rtk = 1'($urandom);
            xv  = ($urandom % 3) != 0;
            xtk = 1'($urandom);
            xtg = $urandom & 32'hffff_fffc;
            if (mq.size() != 0 && ($urandom % 4) != 0) begin
                h   = mq[0];
                xtk = h.tk;
                xtg = (($urandom % 8) == 0) ? h.tg ^ 32'h10 : h.tg;
            end
            step("rand", ($urandom % 3) != 0, rpc, rtk, rtg, xv, xtk, xtg, ($urandom % 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
